// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects push-button pads with sticky press flags
module button_conditioner #(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                       io_mainClk,
  input  logic                       io_resetn,
  input  logic [NUM_BUTTONS-1:0]     io_buttons,
  input  logic [NUM_BUTTONS-1:0]     io_clearSticky,
  output logic [NUM_BUTTONS-1:0]     io_level,
  output logic [NUM_BUTTONS-1:0]     io_pressPulse,
  output logic [NUM_BUTTONS-1:0]     io_releasePulse,
  output logic [NUM_BUTTONS-1:0]     io_pressSticky,
  output logic [2*NUM_BUTTONS-1:0]   io_status
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [NUM_BUTTONS-1:0] pad, s1, s2, differ, flip;
  logic [CW-1:0] cnt [NUM_BUTTONS];
  assign pad = ACTIVE_LOW ? ~io_buttons : io_buttons;
  assign differ = s2 ^ io_level;
  assign io_status = {io_pressSticky, io_level};
  always_comb begin
    flip = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) flip[i] = differ[i] && cnt[i] == LAST;
  end
  // a set on the flip edge beats a simultaneous clear so no press is lost
  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      s1              <= '0;
      s2              <= '0;
      io_level        <= '0;
      io_pressPulse   <= '0;
      io_releasePulse <= '0;
      io_pressSticky  <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      s1              <= pad;
      s2              <= s1;
      io_level        <= io_level ^ flip;
      io_pressPulse   <= flip & s2;
      io_releasePulse <= flip & ~s2;
      io_pressSticky  <= (flip & s2) | (io_pressSticky & ~io_clearSticky);
      for (int i = 0; i < NUM_BUTTONS; i++) cnt[i] <= differ[i] && !flip[i] ? cnt[i] + CW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table, directed and random checks of both pad polarities against a window model
module tb_button_conditioner;
  localparam int D = 8;
  typedef struct {
    int         n;
    logic       rstn;
    logic [1:0] btn, clr, lvl, prs, rel, stk;
  } vec_t;
  logic clk, rstn;
  logic [1:0] btn, clr, pad1;
  logic [1:0] lvl0, prs0, rel0, stk0, lvl1, prs1, rel1, stk1;
  logic [3:0] st0, st1;
  logic [1:0] m_lvl, m_prs, m_rel, m_stk;
  logic [1:0] pad_q[$], ev_q[$];
  int n_chk = 0, n_fail = 0;
  vec_t tbl [25];
  assign pad1 = ~btn;
  button_conditioner #(.NUM_BUTTONS(2), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut0 (
    .io_mainClk(clk), .io_resetn(rstn), .io_buttons(btn), .io_clearSticky(clr),
    .io_level(lvl0), .io_pressPulse(prs0), .io_releasePulse(rel0), .io_pressSticky(stk0), .io_status(st0));
  button_conditioner #(.NUM_BUTTONS(2), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut1 (
    .io_mainClk(clk), .io_resetn(rstn), .io_buttons(pad1), .io_clearSticky(clr),
    .io_level(lvl1), .io_pressPulse(prs1), .io_releasePulse(rel1), .io_pressSticky(stk1), .io_status(st1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // level flips once the last D synchronised samples all disagree with it
  task automatic model_edge(input logic r, input logic [1:0] b, input logic [1:0] c);
    logic [1:0] s2v, flip;
    if (!r) begin
      pad_q.delete();
      ev_q.delete();
      m_lvl = '0; m_prs = '0; m_rel = '0; m_stk = '0;
      return;
    end
    s2v = pad_q.size() >= 2 ? pad_q[pad_q.size()-2] : 2'b00;
    ev_q.push_back(s2v);
    pad_q.push_back(b);
    if (ev_q.size() > D) void'(ev_q.pop_front());
    if (pad_q.size() > 2) void'(pad_q.pop_front());
    for (int ch = 0; ch < 2; ch++) begin
      flip[ch] = ev_q.size() == D;
      foreach (ev_q[j]) if (ev_q[j][ch] == m_lvl[ch]) flip[ch] = 1'b0;
    end
    m_prs = flip & ~m_lvl;
    m_rel = flip & m_lvl;
    m_stk = m_prs | (m_stk & ~c);
    m_lvl = m_lvl ^ flip;
  endtask
  task automatic step(input logic r, input logic [1:0] b, input logic [1:0] c);
    rstn = r; btn = b; clr = c;
    @(posedge clk);
    model_edge(r, b, c);
    #1;
    chk("dut0_status", st0, {m_stk, m_lvl});
    chk("dut0_ports", {stk0, lvl0}, {m_stk, m_lvl});
    chk("dut0_pulses", {rel0, prs0}, {m_rel, m_prs});
    chk("dut1_status", st1, {m_stk, m_lvl});
    chk("dut1_ports", {stk1, lvl1}, {m_stk, m_lvl});
    chk("dut1_pulses", {rel1, prs1}, {m_rel, m_prs});
    @(negedge clk);
  endtask
  initial begin
    int n;
    logic [1:0] nb, nc;
    rstn = 1'b0; btn = 2'b00; clr = 2'b00;
    tbl[0]  = '{3, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{9, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11};
    tbl[3]  = '{1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[4]  = '{9, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[5]  = '{1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
    tbl[6]  = '{1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    tbl[7]  = '{1, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{9, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{1, 1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    tbl[10] = '{1, 1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    tbl[11] = '{9, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    tbl[12] = '{1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    tbl[13] = '{1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[14] = '{7, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[15] = '{1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[16] = '{7, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[17] = '{2, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[18] = '{1, 1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    tbl[19] = '{1, 1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    tbl[20] = '{9, 1'b1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    tbl[21] = '{1, 1'b1, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b11};
    tbl[22] = '{1, 1'b1, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[23] = '{1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[24] = '{2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    @(negedge clk);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rstn, tbl[i].btn, tbl[i].clr);
      chk($sformatf("tbl%0d_dut0_status", i), st0, {tbl[i].stk, tbl[i].lvl});
      chk($sformatf("tbl%0d_dut0_pulses", i), {rel0, prs0}, {tbl[i].rel, tbl[i].prs});
      chk($sformatf("tbl%0d_dut1_status", i), st1, {tbl[i].stk, tbl[i].lvl});
      chk($sformatf("tbl%0d_dut1_pulses", i), {rel1, prs1}, {tbl[i].rel, tbl[i].prs});
    end
    for (int k = 0; k < 5; k++) step(1'b1, 2'b01, 2'b00);
    step(1'b0, 2'b01, 2'b00);
    n = 0;
    do begin
      step(1'b1, 2'b01, 2'b00);
      n++;
    end while (!lvl0[0] && n < 30);
    chk("held_through_reset_latency", n, D + 2);
    chk("held_through_reset_pulse", prs0, 2'b01);
    n = 0;
    do begin
      step(1'b1, 2'b11, 2'b11);
      n++;
    end while (!prs0[1] && n < 30);
    chk("clear_held_latency", n, D + 2);
    chk("clear_held_set", stk0, 2'b10);
    step(1'b1, 2'b11, 2'b11);
    chk("clear_held_drop", stk0, 2'b00);
    nb = btn;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 11) == 0) nb[c] = ~nb[c];
        nc[c] = $urandom_range(0, 15) == 0;
      end
      step($urandom_range(0, 999) != 0, nb, nc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
